// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - state encoding shared by the serial subtractor
package serial_sub_pkg;

   localparam logic [1:0] IDLE_ENC = 2'b00;
   localparam logic [1:0] RUN_ENC  = 2'b01;
   localparam logic [1:0] DONE_ENC = 2'b10;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      RUN  = RUN_ENC,
      DONE = DONE_ENC
   } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full-subtractor cell
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, with request/response handshakes
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             start_ready_q, start_ready_d;
   logic             done_valid_q, done_valid_d;
   logic             busy_q, busy_d;
   logic             cell_d, cell_bout;

   full_subtractor u_cell (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      diff_sh_d = diff_sh_q;
      borrow_d  = borrow_q;
      cnt_d     = cnt_q;
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      case (state_q)
         IDLE: begin
            if (start_valid && start_ready_q) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               state_d  = RUN;
            end
         end
         RUN: begin
            // Result bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
            diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
            a_sh_d    = a_sh_q >> 1;
            b_sh_d    = b_sh_q >> 1;
            borrow_d  = cell_bout;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (done_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      start_ready_d = (state_d == IDLE);
      done_valid_d  = (state_d == DONE);
      busy_d        = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         a_sh_q        <= '0;
         b_sh_q        <= '0;
         diff_sh_q     <= '0;
         borrow_q      <= 1'b0;
         cnt_q         <= '0;
         a_msb_q       <= 1'b0;
         b_msb_q       <= 1'b0;
         start_ready_q <= 1'b1;
         done_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_sh_q        <= a_sh_d;
         b_sh_q        <= b_sh_d;
         diff_sh_q     <= diff_sh_d;
         borrow_q      <= borrow_d;
         cnt_q         <= cnt_d;
         a_msb_q       <= a_msb_d;
         b_msb_q       <= b_msb_d;
         start_ready_q <= start_ready_d;
         done_valid_q  <= done_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign start_ready = start_ready_q;
   assign done_valid  = done_valid_q;
   assign busy        = busy_q;
   assign diff        = diff_sh_q;
   assign borrow_out  = borrow_q;
   assign ovf         = (a_msb_q != b_msb_q) & (diff_sh_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_valid;
   logic       start_ready;
   logic [7:0] a, b;
   logic       done_valid;
   logic       done_ready;
   logic [7:0] diff;
   logic       borrow_out;
   logic       ovf;
   logic       busy;

   logic       fx, fy, fbin, fd, fbout;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .diff        (diff),
      .borrow_out  (borrow_out),
      .ovf         (ovf),
      .busy        (busy)
   );

   full_subtractor u_cell_ut (
      .x    (fx),
      .y    (fy),
      .bin  (fbin),
      .d    (fd),
      .bout (fbout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, start_ready, 1);
      check({tag, "_done_valid"}, done_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_diff"}, diff, 0);
      check({tag, "_borrow_out"}, borrow_out, 0);
      check({tag, "_ovf"}, ovf, 0);
   endtask

   // Handshake happens on the posedge inside; operands are scrambled right after.
   task automatic issue(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      a = av;
      b = bv;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
   endtask

   task automatic wait_done(input string tag, output int cycles);
      cycles = 0;
      while (cycles < 40 && done_valid !== 1'b1) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, "_done_seen"}, done_valid, 1);
   endtask

   task automatic run_case(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] ed, input logic eb, input logic eo);
      int cyc;
      issue(av, bv);
      wait_done(tag, cyc);
      check({tag, "_diff"}, diff, ed);
      check({tag, "_borrow_out"}, borrow_out, eb);
      check({tag, "_ovf"}, ovf, eo);
      @(posedge clk);
      #1;
      check({tag, "_released"}, done_valid, 0);
   endtask

   initial begin
      int cyc;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      done_ready  = 1'b0;
      a           = 8'h00;
      b           = 8'h00;
      fx = 1'b0; fy = 1'b0; fbin = 1'b0;

      for (int i = 0; i < 8; i++) begin
         int r;
         {fx, fy, fbin} = 3'(i);
         #1;
         r = int'(fx) - int'(fy) - int'(fbin);
         check($sformatf("cell_d_%0d", i), fd, r & 1);
         check($sformatf("cell_bout_%0d", i), fbout, (r < 0) ? 1 : 0);
      end

      #2;
      check_reset_outputs("in_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outputs("after_reset");

      done_ready = 1'b1;
      issue(8'h5A, 8'h3C);
      check("t1_start_ready_low", start_ready, 0);
      check("t1_busy", busy, 1);
      wait_done("t1", cyc);
      check("t1_latency", cyc, 8);
      check("t1_diff", diff, 8'h1E);
      check("t1_borrow_out", borrow_out, 0);
      check("t1_ovf", ovf, 0);
      @(posedge clk);
      #1;
      check("t1_pulse_one_cycle", done_valid, 0);
      check("t1_idle_ready", start_ready, 1);

      run_case("t2", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_case("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_case("t4", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      done_ready = 1'b0;
      issue(8'h10, 8'h20);
      wait_done("bp", cyc);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid_%0d", i), done_valid, 1);
         check($sformatf("bp_diff_%0d", i), diff, 8'hF0);
         check($sformatf("bp_borrow_%0d", i), borrow_out, 1);
         check($sformatf("bp_ovf_%0d", i), ovf, 0);
         check($sformatf("bp_start_ready_%0d", i), start_ready, 0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_accepted", done_valid, 0);
      check("bp_start_ready", start_ready, 1);

      issue(8'h0F, 8'h03);
      @(negedge clk);
      a = 8'hFF;
      b = 8'h01;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      check("mid_busy", busy, 1);
      wait_done("mid", cyc);
      check("mid_diff", diff, 8'h0C);
      check("mid_borrow", borrow_out, 0);
      @(posedge clk);
      #1;

      issue(8'hAA, 8'h55);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (12) @(posedge clk);
      #1;
      check("rst_hold_no_done", done_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_released_ready", start_ready, 1);
      run_case("post_rst", 8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
